// File: rtl/nanorv32_trace_pkg.sv
// Shared definitions for the retire trace formatter: FSM states, ASCII constants,
// RV32I mnemonic decode and ABI register naming.
package nanorv32_trace_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } trace_state_t;

    localparam logic [7:0]  CH_SPACE = 8'h20;
    localparam logic [7:0]  CH_NL    = 8'h0a;
    localparam logic [47:0] MN_UNDEF = "UNDEF ";

    // Match patterns follow the core decoder so trace and execution agree on unknown encodings.
    function automatic logic [47:0] decode_mnem(input logic [31:0] instr);
        logic [47:0] m;
        m = MN_UNDEF;
        casez (instr)
            32'b???????_?????_?????_???_?????_0110111: m = "LUI   ";
            32'b???????_?????_?????_???_?????_0010111: m = "AUIPC ";
            32'b???????_?????_?????_???_?????_1101111: m = "JAL   ";
            32'b???????_?????_?????_000_?????_1100111: m = "JALR  ";
            32'b???????_?????_?????_000_?????_1100011: m = "BEQ   ";
            32'b???????_?????_?????_001_?????_1100011: m = "BNE   ";
            32'b???????_?????_?????_100_?????_1100011: m = "BLT   ";
            32'b???????_?????_?????_101_?????_1100011: m = "BGE   ";
            32'b???????_?????_?????_110_?????_1100011: m = "BLTU  ";
            32'b???????_?????_?????_111_?????_1100011: m = "BGEU  ";
            32'b???????_?????_?????_000_?????_0000011: m = "LB    ";
            32'b???????_?????_?????_001_?????_0000011: m = "LH    ";
            32'b???????_?????_?????_010_?????_0000011: m = "LW    ";
            32'b???????_?????_?????_100_?????_0000011: m = "LBU   ";
            32'b???????_?????_?????_101_?????_0000011: m = "LHU   ";
            32'b???????_?????_?????_000_?????_0100011: m = "SB    ";
            32'b???????_?????_?????_001_?????_0100011: m = "SH    ";
            32'b???????_?????_?????_010_?????_0100011: m = "SW    ";
            32'b???????_?????_?????_000_?????_0010011: m = "ADDI  ";
            32'b???????_?????_?????_010_?????_0010011: m = "SLTI  ";
            32'b???????_?????_?????_011_?????_0010011: m = "SLTIU ";
            32'b???????_?????_?????_100_?????_0010011: m = "XORI  ";
            32'b???????_?????_?????_110_?????_0010011: m = "ORI   ";
            32'b???????_?????_?????_111_?????_0010011: m = "ANDI  ";
            32'b0000000_?????_?????_001_?????_0010011: m = "SLLI  ";
            32'b0000000_?????_?????_101_?????_0010011: m = "SRLI  ";
            32'b0100000_?????_?????_101_?????_0010011: m = "SRAI  ";
            32'b0000000_?????_?????_000_?????_0110011: m = "ADD   ";
            32'b0100000_?????_?????_000_?????_0110011: m = "SUB   ";
            32'b0000000_?????_?????_001_?????_0110011: m = "SLL   ";
            32'b0000000_?????_?????_010_?????_0110011: m = "SLT   ";
            32'b0000000_?????_?????_011_?????_0110011: m = "SLTU  ";
            32'b0000000_?????_?????_100_?????_0110011: m = "XOR   ";
            32'b0000000_?????_?????_101_?????_0110011: m = "SRL   ";
            32'b0100000_?????_?????_101_?????_0110011: m = "SRA   ";
            32'b0000000_?????_?????_110_?????_0110011: m = "OR    ";
            32'b0000000_?????_?????_111_?????_0110011: m = "AND   ";
            32'b???????_?????_?????_000_?????_0001111: m = "FENCE ";
            32'b0000000_00000_00000_000_00000_1110011: m = "ECALL ";
            32'b0000000_00001_00000_000_00000_1110011: m = "EBREAK";
            default:                                   m = MN_UNDEF;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] reg_name(input logic [4:0] r);
        logic [31:0] n;
        n = "zero";
        case (r)
            5'd0:  n = "zero";
            5'd1:  n = "ra  ";
            5'd2:  n = "sp  ";
            5'd3:  n = "gp  ";
            5'd4:  n = "tp  ";
            5'd5:  n = "t0  ";
            5'd6:  n = "t1  ";
            5'd7:  n = "t2  ";
            5'd8:  n = "s0  ";
            5'd9:  n = "s1  ";
            5'd10: n = "a0  ";
            5'd11: n = "a1  ";
            5'd12: n = "a2  ";
            5'd13: n = "a3  ";
            5'd14: n = "a4  ";
            5'd15: n = "a5  ";
            5'd16: n = "a6  ";
            5'd17: n = "a7  ";
            5'd18: n = "s2  ";
            5'd19: n = "s3  ";
            5'd20: n = "s4  ";
            5'd21: n = "s5  ";
            5'd22: n = "s6  ";
            5'd23: n = "s7  ";
            5'd24: n = "s8  ";
            5'd25: n = "s9  ";
            5'd26: n = "s10 ";
            5'd27: n = "s11 ";
            5'd28: n = "t3  ";
            5'd29: n = "t4  ";
            5'd30: n = "t5  ";
            5'd31: n = "t6  ";
            default: n = "zero";
        endcase
        return n;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

endpackage

// File: rtl/nanorv32_trace_lut.sv
// Combinational lookup from an instruction word to its padded mnemonic and
// the ABI names of the raw rd/rs1/rs2 fields.
module nanorv32_trace_lut
    import nanorv32_trace_pkg::*;
(
    input  logic [31:0] instr,
    output logic [47:0] mnem,
    output logic [31:0] rd_name,
    output logic [31:0] rs1_name,
    output logic [31:0] rs2_name
);

    // Register fields are named even for formats that do not use them.
    assign mnem     = decode_mnem(instr);
    assign rd_name  = reg_name(instr[11:7]);
    assign rs1_name = reg_name(instr[19:15]);
    assign rs2_name = reg_name(instr[24:20]);

endmodule

// File: rtl/nanorv32_trace_fmt.sv
// Retire trace formatter: buffers retired {pc, instr} pairs and streams one ASCII
// line per instruction over a valid/ready byte interface.
module nanorv32_trace_fmt
    import nanorv32_trace_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 32,
    parameter int SHOW_REGS = 1,
    parameter int DROP_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trace_en,
    input  logic              retire_valid,
    input  logic [ADDR_W-1:0] retire_pc,
    input  logic [31:0]       retire_instr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int HEX_DIGITS = ADDR_W / 4;
    localparam int LINE_LEN   = HEX_DIGITS + 8 + ((SHOW_REGS != 0) ? 15 : 0);
    localparam int CHAR_W     = $clog2(LINE_LEN);
    localparam logic [CHAR_W-1:0] LAST_IDX = CHAR_W'(LINE_LEN - 1);

    logic [ADDR_W-1:0] fifo_pc    [DEPTH];
    logic [31:0]       fifo_instr [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;

    trace_state_t      state;
    trace_state_t      state_next;
    logic [CHAR_W-1:0] char_idx;
    logic [ADDR_W-1:0] line_pc;
    logic [31:0]       line_instr;
    logic [7:0]        line_char;

    logic [47:0]       mnem;
    logic [31:0]       rd_name;
    logic [31:0]       rs1_name;
    logic [31:0]       rs2_name;

    int                pos;
    int                rel;
    int                fld;
    int                fpos;
    logic [31:0]       fld_name;

    // The extra pointer MSB separates full from empty when the indices coincide.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_req   = retire_valid & trace_en;
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;
    assign busy       = ~fifo_empty | (state == ST_EMIT);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr[PTR_W-1:0]]    <= retire_pc;
            fifo_instr[wr_ptr[PTR_W-1:0]] <= retire_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                tx_valid = 1'b1;
                if (tx_ready && (char_idx == LAST_IDX)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= '0;
            char_idx   <= '0;
            line_pc    <= '0;
            line_instr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + (PTR_W+1)'(1);
                line_pc    <= fifo_pc[rd_ptr[PTR_W-1:0]];
                line_instr <= fifo_instr[rd_ptr[PTR_W-1:0]];
                char_idx   <= '0;
            end else if (tx_valid && tx_ready && (char_idx != LAST_IDX)) begin
                char_idx <= char_idx + CHAR_W'(1);
            end
            if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    nanorv32_trace_lut u_lut (
        .instr    (line_instr),
        .mnem     (mnem),
        .rd_name  (rd_name),
        .rs1_name (rs1_name),
        .rs2_name (rs2_name)
    );

    // Register section is three 5-char slots: a separator space followed by a 4-char name.
    always_comb begin
        pos       = 32'(char_idx);
        rel       = 0;
        fld       = 0;
        fpos      = 0;
        fld_name  = rd_name;
        line_char = CH_NL;
        if (pos == LINE_LEN - 1) begin
            line_char = CH_NL;
        end else if (pos < HEX_DIGITS) begin
            line_char = hex_char(4'(line_pc >> (4 * (HEX_DIGITS - 1 - pos))));
        end else if (pos == HEX_DIGITS) begin
            line_char = CH_SPACE;
        end else if (pos <= HEX_DIGITS + 6) begin
            line_char = 8'(mnem >> (8 * (HEX_DIGITS + 6 - pos)));
        end else if (SHOW_REGS != 0) begin
            rel  = pos - (HEX_DIGITS + 7);
            fld  = rel / 5;
            fpos = rel % 5;
            if (fld == 1) begin
                fld_name = rs1_name;
            end else if (fld == 2) begin
                fld_name = rs2_name;
            end
            if (fpos == 0) begin
                line_char = CH_SPACE;
            end else begin
                line_char = 8'(fld_name >> (8 * (4 - fpos)));
            end
        end
    end

    assign tx_data = (state == ST_EMIT) ? line_char : 8'h00;

endmodule

// File: tb/tb_nanorv32_trace_fmt.sv
// Directed bench for the retire trace formatter: line content, latency, backpressure,
// drops, reset abort and the PC+mnemonic-only variant.
module tb_nanorv32_trace_fmt;

    logic        clk;
    logic        rst_n;
    logic        trace_en;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  drop_cnt;
    logic        busy;

    logic        trace_en0;
    logic        retire_valid0;
    logic [31:0] retire_pc0;
    logic [31:0] retire_instr0;
    logic [7:0]  tx_data0;
    logic        tx_valid0;
    logic        tx_ready0;
    logic [15:0] drop_cnt0;
    logic        busy0;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] rx0_q[$];
    int         acc_cyc_q[$];
    int         cyc = 0;
    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    logic [31:0] bp_pc    [6] = '{32'h200, 32'h204, 32'h208, 32'h20c, 32'h210, 32'h214};
    logic [31:0] bp_instr [6] = '{32'h00A50533, 32'h40B50533, 32'hFFFFFFFF,
                                  32'h00000073, 32'h0000006F, 32'h00500093};
    logic [31:0] rr_pc    [3] = '{32'h600, 32'h604, 32'h608};
    logic [31:0] rr_instr [3] = '{32'h40B50533, 32'h00500093, 32'h0000006F};

    nanorv32_trace_fmt #(.DEPTH(4), .ADDR_W(32), .SHOW_REGS(1), .DROP_W(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_en     (trace_en),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    nanorv32_trace_fmt #(.DEPTH(4), .ADDR_W(32), .SHOW_REGS(0), .DROP_W(16)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_en     (trace_en0),
        .retire_valid (retire_valid0),
        .retire_pc    (retire_pc0),
        .retire_instr (retire_instr0),
        .tx_data      (tx_data0),
        .tx_valid     (tx_valid0),
        .tx_ready     (tx_ready0),
        .drop_cnt     (drop_cnt0),
        .busy         (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte sink: records accepted bytes and flags tx_data changes during a stall.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && tx_valid && (tx_data !== prev_data)) stall_viol++;
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                if (tx_valid && tx_ready) begin
                    rx_q.push_back(tx_data);
                    acc_cyc_q.push_back(cyc);
                end
                if (tx_valid0 && tx_ready0) rx0_q.push_back(tx_data0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] rx_byte(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 8'h00;
    endfunction

    function automatic logic [7:0] rx0_byte(input int idx);
        if (idx < rx0_q.size()) return rx0_q[idx];
        return 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        trace_en      = 1'b1;
        retire_valid  = 1'b0;
        retire_pc     = '0;
        retire_instr  = '0;
        tx_ready      = 1'b1;
        trace_en0     = 1'b1;
        retire_valid0 = 1'b0;
        retire_pc0    = '0;
        retire_instr0 = '0;
        tx_ready0     = 1'b1;
        repeat (3) step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %02h expected 00", tx_data); end
        checks++; if (drop_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid0: got %b expected 0", tx_valid0); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_line();
        string exp;
        int    base;
        bit    ok;
        exp  = "00000100 ADD    a0   a0   a0  \n";
        base = rx_q.size();
        retire_valid = 1'b1; retire_pc = 32'h100; retire_instr = 32'h00A50533;
        step();
        retire_valid = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_latency_n1: tx_valid got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL add_busy: got %b expected 1", busy); end
        step();
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_latency_n2: tx_valid got %b expected 1", tx_valid); end
        checks++; if (tx_data !== 8'h30) begin errors++; $display("[TB] FAIL add_first_char: got %02h expected 30", tx_data); end
        wait_idle(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL add_timeout: idle reached %b expected 1", ok); end
        checks++; if (rx_q.size() - base !== 31) begin errors++; $display("[TB] FAIL add_len: got %0d expected 31", rx_q.size() - base); end
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] e;
            e = exp[i];
            checks++;
            if (rx_byte(base + i) !== e) begin
                errors++;
                $display("[TB] FAIL add_byte[%0d]: got %02h expected %02h", i, rx_byte(base + i), e);
            end
        end
        checks++; if (drop_cnt !== 4'd0) begin errors++; $display("[TB] FAIL add_drop_cnt: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_addi_fields();
        string exp;
        int    base;
        bit    ok;
        exp  = "00000104 ADDI   ra   zero t0  \n";
        base = rx_q.size();
        retire_valid = 1'b1; retire_pc = 32'h104; retire_instr = 32'h00500093;
        step();
        retire_valid = 1'b0;
        step();
        wait_idle(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL addi_timeout: idle reached %b expected 1", ok); end
        checks++; if (rx_q.size() - base !== 31) begin errors++; $display("[TB] FAIL addi_len: got %0d expected 31", rx_q.size() - base); end
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] e;
            e = exp[i];
            checks++;
            if (rx_byte(base + i) !== e) begin
                errors++;
                $display("[TB] FAIL addi_byte[%0d]: got %02h expected %02h", i, rx_byte(base + i), e);
            end
        end
    endtask

    task automatic test_backpressure();
        string exp;
        int    base;
        int    cbase;
        int    span;
        bit    ok;
        exp = {"00000200 ADD    a0   a0   a0  \n",
               "00000204 SUB    a0   a0   a1  \n",
               "00000208 UNDEF  t6   t6   t6  \n",
               "0000020c ECALL  zero zero zero\n",
               "00000210 JAL    zero zero zero\n"};
        base  = rx_q.size();
        cbase = acc_cyc_q.size();
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            retire_valid = 1'b1; retire_pc = bp_pc[k]; retire_instr = bp_instr[k];
            step();
        end
        retire_valid = 1'b0;
        checks++; if (drop_cnt !== 4'd1) begin errors++; $display("[TB] FAIL bp_drop_cnt: got %0d expected 1", drop_cnt); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_tx_valid: got %b expected 1", tx_valid); end
        repeat (5) step();
        checks++; if (rx_q.size() !== base) begin errors++; $display("[TB] FAIL bp_stalled: got %0d bytes expected 0", rx_q.size() - base); end
        checks++; if (tx_data !== 8'h30) begin errors++; $display("[TB] FAIL bp_held_char: got %02h expected 30", tx_data); end
        tx_ready = 1'b1;
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL bp_timeout: idle reached %b expected 1", ok); end
        checks++; if (rx_q.size() - base !== 155) begin errors++; $display("[TB] FAIL bp_len: got %0d expected 155", rx_q.size() - base); end
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] e;
            e = exp[i];
            checks++;
            if (rx_byte(base + i) !== e) begin
                errors++;
                $display("[TB] FAIL bp_byte[%0d]: got %02h expected %02h", i, rx_byte(base + i), e);
            end
        end
        span = (acc_cyc_q.size() >= cbase + 155) ? acc_cyc_q[cbase + 154] - acc_cyc_q[cbase] : -1;
        checks++; if (span !== 158) begin errors++; $display("[TB] FAIL bp_span: got %0d cycles expected 158", span); end
    endtask

    task automatic test_random_ready();
        string exp;
        int    base;
        int    sbase;
        bit    done;
        exp = {"00000600 SUB    a0   a0   a1  \n",
               "00000604 ADDI   ra   zero t0  \n",
               "00000608 JAL    zero zero zero\n"};
        base  = rx_q.size();
        sbase = stall_viol;
        done  = 1'b0;
        for (int c = 0; c < 800 && !done; c++) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (c < 3) begin
                retire_valid = 1'b1; retire_pc = rr_pc[c]; retire_instr = rr_instr[c];
            end else begin
                retire_valid = 1'b0;
            end
            step();
            if (c >= 3 && !busy) done = 1'b1;
        end
        tx_ready = 1'b1;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rr_timeout: idle reached %b expected 1", done); end
        checks++; if (stall_viol - sbase !== 0) begin errors++; $display("[TB] FAIL rr_stable: got %0d changes expected 0", stall_viol - sbase); end
        checks++; if (rx_q.size() - base !== 93) begin errors++; $display("[TB] FAIL rr_len: got %0d expected 93", rx_q.size() - base); end
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] e;
            e = exp[i];
            checks++;
            if (rx_byte(base + i) !== e) begin
                errors++;
                $display("[TB] FAIL rr_byte[%0d]: got %02h expected %02h", i, rx_byte(base + i), e);
            end
        end
    endtask

    task automatic test_reset_midline();
        string exp;
        string exp0;
        int    base;
        int    base0;
        bit    ok;
        bit    ok0;
        exp  = "00000304 ADD    a0   a0   a0  \n";
        exp0 = "00000400 ADDI  \n";
        tx_ready = 1'b1;
        base = rx_q.size();
        retire_valid = 1'b1; retire_pc = 32'h300; retire_instr = 32'h00A50533;
        step();
        retire_valid = 1'b0;
        for (int c = 0; c < 60 && (rx_q.size() - base) < 10; c++) step();
        checks++; if (rx_q.size() - base !== 10) begin errors++; $display("[TB] FAIL rst_reach_char10: got %0d expected 10", rx_q.size() - base); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_tx_data: got %02h expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (drop_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_drop_cnt: got %0d expected 0", drop_cnt); end
        step();
        rst_n = 1'b1;
        step();
        base = rx_q.size();
        retire_valid = 1'b1; retire_pc = 32'h304; retire_instr = 32'h00A50533;
        step();
        retire_valid = 1'b0;
        wait_idle(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rst_fresh_timeout: idle reached %b expected 1", ok); end
        checks++; if (rx_q.size() - base !== 31) begin errors++; $display("[TB] FAIL rst_fresh_len: got %0d expected 31", rx_q.size() - base); end
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] e;
            e = exp[i];
            checks++;
            if (rx_byte(base + i) !== e) begin
                errors++;
                $display("[TB] FAIL rst_fresh_byte[%0d]: got %02h expected %02h", i, rx_byte(base + i), e);
            end
        end
        base0 = rx0_q.size();
        retire_valid0 = 1'b1; retire_pc0 = 32'h400; retire_instr0 = 32'h00500093;
        step();
        retire_valid0 = 1'b0;
        ok0 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy0) begin
                ok0 = 1'b1;
                break;
            end
            step();
        end
        checks++; if (ok0 !== 1'b1) begin errors++; $display("[TB] FAIL noregs_timeout: idle reached %b expected 1", ok0); end
        checks++; if (rx0_q.size() - base0 !== 16) begin errors++; $display("[TB] FAIL noregs_len: got %0d expected 16", rx0_q.size() - base0); end
        for (int i = 0; i < exp0.len(); i++) begin
            logic [7:0] e;
            e = exp0[i];
            checks++;
            if (rx0_byte(base0 + i) !== e) begin
                errors++;
                $display("[TB] FAIL noregs_byte[%0d]: got %02h expected %02h", i, rx0_byte(base0 + i), e);
            end
        end
        checks++; if (drop_cnt0 !== 16'd0) begin errors++; $display("[TB] FAIL noregs_drop_cnt: got %0d expected 0", drop_cnt0); end
    endtask

    task automatic test_undef_and_drops();
        string exp;
        int    base;
        bit    ok;
        exp  = "00000500 UNDEF  t6   t6   t6  \n";
        tx_ready = 1'b1;
        base = rx_q.size();
        retire_valid = 1'b1; retire_pc = 32'h500; retire_instr = 32'hFFFFFFFF;
        step();
        retire_valid = 1'b0;
        step();
        wait_idle(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL undef_timeout: idle reached %b expected 1", ok); end
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] e;
            e = exp[i];
            checks++;
            if (rx_byte(base + i) !== e) begin
                errors++;
                $display("[TB] FAIL undef_byte[%0d]: got %02h expected %02h", i, rx_byte(base + i), e);
            end
        end
        base = rx_q.size();
        trace_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            retire_valid = 1'b1; retire_pc = 32'h700 + 32'(4 * k); retire_instr = 32'h00A50533;
            step();
        end
        retire_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL disabled_busy: got %b expected 0", busy); end
        checks++; if (drop_cnt !== 4'd0) begin errors++; $display("[TB] FAIL disabled_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (rx_q.size() !== base) begin errors++; $display("[TB] FAIL disabled_bytes: got %0d expected 0", rx_q.size() - base); end
        trace_en = 1'b1;
        tx_ready = 1'b0;
        for (int k = 0; k < 25; k++) begin
            retire_valid = 1'b1; retire_pc = 32'h800 + 32'(4 * k); retire_instr = 32'h00A50533;
            step();
            if (k == 18) begin
                checks++; if (drop_cnt !== 4'd14) begin errors++; $display("[TB] FAIL drop_count_14: got %0d expected 14", drop_cnt); end
            end
        end
        retire_valid = 1'b0;
        checks++; if (drop_cnt !== 4'hF) begin errors++; $display("[TB] FAIL drop_saturate: got %0d expected 15", drop_cnt); end
        tx_ready = 1'b1;
        wait_idle(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL drain_timeout: idle reached %b expected 1", ok); end
        checks++; if (drop_cnt !== 4'hF) begin errors++; $display("[TB] FAIL drop_hold: got %0d expected 15", drop_cnt); end
    endtask

    initial begin
        $display("[TB] starting nanorv32_trace_fmt bench");
        test_reset();
        test_add_line();
        test_addi_fields();
        test_backpressure();
        test_random_ready();
        test_reset_midline();
        test_undef_and_drops();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
